// File: rtl/spi_temp_sensor_emu_if.sv
// Bus between a host and the LM70-style sensor emulator: chip selects, SCK,
// the split SIO pin and the command/status side-band.
interface spi_temp_sensor_emu_if #(
  parameter int NCH    = 2,
  parameter int DATA_W = 16,
  parameter int CMD_W  = 16
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*DATA_W-1:0] temp_in;
  logic [NCH-1:0]        cs_n;
  logic                  sck;
  logic                  sio_in;
  logic                  sio_out;
  logic                  sio_oe;
  logic                  cmd_valid;
  logic [CMD_W-1:0]      cmd_data;
  logic [CHW-1:0]        cmd_ch;
  logic                  frame_done;
  logic                  cs_err;
  logic [NCH-1:0]        shutdown;

  modport master (
    output temp_in, cs_n, sck, sio_in,
    input  sio_out, sio_oe, cmd_valid, cmd_data, cmd_ch, frame_done, cs_err, shutdown
  );

  modport slave (
    input  temp_in, cs_n, sck, sio_in,
    output sio_out, sio_oe, cmd_valid, cmd_data, cmd_ch, frame_done, cs_err, shutdown
  );
endinterface

// File: rtl/spi_temp_sensor_emu.sv
// Multi-channel LM70-family SPI temperature sensor emulator (read + command phase).
// Define SENSOR_SHUTDOWN_EN to enable shutdown/ID mode driven by all-ones/all-zeros commands.
module spi_temp_sensor_emu #(
  parameter int                NCH     = 2,
  parameter int                DATA_W  = 16,
  parameter int                CMD_W   = 16,
  parameter logic [DATA_W-1:0] ID_CODE = 16'h8001
) (
  input logic                  clk,
  input logic                  rst,
  spi_temp_sensor_emu_if.slave bus
);
  localparam int MAXW = (DATA_W > CMD_W) ? DATA_W : CMD_W;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  // Synchronisers; cs_n resets to idle-high so a held-low pin cannot fake an edge.
  logic [NCH-1:0] cs_s1_q, cs_s2_q, cs_prev_q;
  logic           sck_s1_q, sck_s2_q, sck_prev_q;
  logic           sio_s1_q, sio_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_s1_q    <= '1;
      cs_s2_q    <= '1;
      cs_prev_q  <= '1;
      sck_s1_q   <= 1'b0;
      sck_s2_q   <= 1'b0;
      sck_prev_q <= 1'b0;
      sio_s1_q   <= 1'b0;
      sio_s2_q   <= 1'b0;
    end else begin
      cs_s1_q    <= bus.cs_n;
      cs_s2_q    <= cs_s1_q;
      cs_prev_q  <= cs_s2_q;
      sck_s1_q   <= bus.sck;
      sck_s2_q   <= sck_s1_q;
      sck_prev_q <= sck_s2_q;
      sio_s1_q   <= bus.sio_in;
      sio_s2_q   <= sio_s1_q;
    end
  end

  logic [NCH-1:0]    cs_low, cs_fall;
  logic              sck_rise, sck_fall, cs_multi;
  logic [CHW-1:0]    sel;

  always_comb begin
    cs_low   = ~cs_s2_q;
    cs_fall  = cs_prev_q & ~cs_s2_q;
    sck_rise = ~sck_prev_q & sck_s2_q;
    sck_fall = sck_prev_q & ~sck_s2_q;
    cs_multi = |(cs_low & (cs_low - NCH'(1)));
    sel      = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (cs_low[k]) sel = CHW'(k);
  end

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CMD_W-1:0]  cmd_sh_q, cmd_sh_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CHW-1:0]    ch_q, ch_d;
  logic              oe_q, oe_d;
  logic              frame_done_q, frame_done_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cs_err_q, cs_err_d;
  logic [CMD_W-1:0]  cmd_data_q, cmd_data_d;
  logic [CHW-1:0]    cmd_ch_q, cmd_ch_d;
  logic [NCH-1:0]    sd_q, sd_d;
  logic [CMD_W-1:0]  cmd_nxt;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cmd_sh_d     = cmd_sh_q;
    cnt_d        = cnt_q;
    ch_d         = ch_q;
    oe_d         = oe_q;
    frame_done_d = 1'b0;
    cmd_valid_d  = 1'b0;
    cs_err_d     = 1'b0;
    cmd_data_d   = cmd_data_q;
    cmd_ch_d     = cmd_ch_q;
    cmd_nxt      = {cmd_sh_q[CMD_W-2:0], sio_s2_q};
`ifdef SENSOR_SHUTDOWN_EN
    sd_d         = sd_q;
`else
    sd_d         = '0;
`endif
    if (state_q == S_IDLE) begin
      if (|cs_fall) begin
        ch_d     = sel;
        cs_err_d = cs_multi;
        shift_d  = sd_q[sel] ? ID_CODE : bus.temp_in[sel*DATA_W +: DATA_W];
        cnt_d    = '0;
        oe_d     = 1'b1;
        state_d  = S_READ;
      end
    end else if (cs_s2_q[ch_q]) begin
      // Host released the selected channel: drop whatever phase was in flight.
      oe_d    = 1'b0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_READ: if (sck_fall) begin
          shift_d = {shift_q[DATA_W-2:0], 1'b0};
          if (cnt_q == CW'(DATA_W - 1)) begin
            frame_done_d = 1'b1;
            oe_d         = 1'b0;
            cnt_d        = '0;
            state_d      = S_WRITE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_WRITE: if (sck_rise) begin
          cmd_sh_d = cmd_nxt;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(CMD_W - 1)) begin
            cmd_data_d  = cmd_nxt;
            cmd_ch_d    = ch_q;
            cmd_valid_d = 1'b1;
            state_d     = S_HOLD;
`ifdef SENSOR_SHUTDOWN_EN
            if (&cmd_nxt)       sd_d[ch_q] = 1'b1;
            else if (~|cmd_nxt) sd_d[ch_q] = 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      cmd_sh_q     <= '0;
      cnt_q        <= '0;
      ch_q         <= '0;
      oe_q         <= 1'b0;
      frame_done_q <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cs_err_q     <= 1'b0;
      cmd_data_q   <= '0;
      cmd_ch_q     <= '0;
      sd_q         <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cmd_sh_q     <= cmd_sh_d;
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      oe_q         <= oe_d;
      frame_done_q <= frame_done_d;
      cmd_valid_q  <= cmd_valid_d;
      cs_err_q     <= cs_err_d;
      cmd_data_q   <= cmd_data_d;
      cmd_ch_q     <= cmd_ch_d;
      sd_q         <= sd_d;
    end
  end

  assign bus.sio_out    = shift_q[DATA_W-1];
  assign bus.sio_oe     = oe_q;
  assign bus.frame_done = frame_done_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.cs_err     = cs_err_q;
  assign bus.cmd_data   = cmd_data_q;
  assign bus.cmd_ch     = cmd_ch_q;
  assign bus.shutdown   = sd_q;
endmodule

// File: tb/tb_spi_temp_sensor_emu.sv
// Randomised frame-level bench for spi_temp_sensor_emu against a transaction model
// (per-channel temperature/shutdown, last command), honouring SENSOR_SHUTDOWN_EN.
module tb_spi_temp_sensor_emu;
  localparam int NCH = 2, DW = 16, CWD = 16;
  localparam logic [15:0] ID = 16'h8001;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  spi_temp_sensor_emu_if #(.NCH(NCH), .DATA_W(DW), .CMD_W(CWD)) bus ();
  spi_temp_sensor_emu #(.NCH(NCH), .DATA_W(DW), .CMD_W(CWD), .ID_CODE(ID)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_chk = 0, n_fail = 0;
  int fd_n = 0, cv_n = 0, ce_n = 0;

  // pulse monitors
  always @(negedge clk) if (!rst) begin
    if (bus.frame_done) fd_n++;
    if (bus.cmd_valid)  cv_n++;
    if (bus.cs_err)     ce_n++;
  end

  // model state
  logic [15:0]    tmp [NCH];
  logic [NCH-1:0] m_sd;
  logic [15:0]    m_cmd;
  logic           m_ch;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Host side of one frame: nrd SCK cycles of read, then ncmd command bits.
  task automatic frame(input logic [1:0] csv, input int nrd, input int ncmd,
                       input logic [15:0] cmd, output logic [15:0] rd);
    logic [15:0] c;
    c  = cmd;
    rd = '0;
    bus.cs_n = csv;
    wclk(2);
    chk("oe_latency", bus.sio_oe, 0);
    wclk(1);
    chk("oe_start", bus.sio_oe, 1);
    bus.temp_in = {$urandom, $urandom};
    for (int i = 0; i < nrd; i++) begin
      rd = {rd[14:0], bus.sio_out};
      bus.sck = 1'b1; wclk(4);
      bus.sck = 1'b0; wclk(4);
    end
    if (nrd == DW) chk("oe_end", bus.sio_oe, 0);
    for (int j = 0; j < ncmd; j++) begin
      bus.sio_in = c[15-j]; wclk(4);
      bus.sck = 1'b1; wclk(4);
      bus.sck = 1'b0;
    end
    wclk(4);
    bus.cs_n = '1;
    bus.sio_in = 1'b0;
    wclk(6);
    chk("oe_idle", bus.sio_oe, 0);
  endtask

  task automatic txn(input logic [1:0] csv, input int nrd, input int ncmd,
                     input logic [15:0] cmd, input logic [31:0] tv);
    int ch, fd0, cv0, ce0;
    logic [15:0] exp, rd;
    tmp[0] = tv[15:0];
    tmp[1] = tv[31:16];
    bus.temp_in = tv;
    ch = csv[0] ? 1 : 0;
    exp = m_sd[ch] ? ID : tmp[ch];
    fd0 = fd_n; cv0 = cv_n; ce0 = ce_n;
    frame(csv, nrd, ncmd, cmd, rd);
    if (nrd > 0) chk("rd_word", rd, 32'(exp) >> (DW - nrd));
    chk("frame_done", fd_n - fd0, (nrd == DW) ? 1 : 0);
    chk("cs_err", ce_n - ce0, ($countones(~csv) > 1) ? 1 : 0);
    if (nrd == DW && ncmd == CWD) begin
      m_cmd = cmd;
      m_ch  = 1'(ch);
`ifdef SENSOR_SHUTDOWN_EN
      if (cmd == 16'hFFFF)      m_sd[ch] = 1'b1;
      else if (cmd == 16'h0000) m_sd[ch] = 1'b0;
`endif
      chk("cmd_valid", cv_n - cv0, 1);
    end else begin
      chk("cmd_valid", cv_n - cv0, 0);
    end
    chk("cmd_data", bus.cmd_data, m_cmd);
    chk("cmd_ch", bus.cmd_ch, m_ch);
    chk("shutdown", bus.shutdown, m_sd);
  endtask

  initial begin
    logic [1:0]  csv;
    logic [15:0] cmd, rd;
    int nrd, ncmd, r;
    bus.cs_n = '1; bus.sck = 1'b0; bus.sio_in = 1'b0; bus.temp_in = '0;
    m_sd = '0; m_cmd = '0; m_ch = 1'b0;
    wclk(3);
    chk("rst_oe", bus.sio_oe, 0);
    chk("rst_out", bus.sio_out, 0);
    chk("rst_pulses", {bus.cmd_valid, bus.frame_done, bus.cs_err}, 0);
    chk("rst_cmd", bus.cmd_data, 0);
    chk("rst_sd", bus.shutdown, 0);
    rst = 1'b0;
    wclk(3);

    txn(2'b10, 16, 0, 16'h0, {16'h1234, 16'h0033});
    txn(2'b01, 16, 16, 16'hFFFF, $urandom);
    txn(2'b01, 16, 0, 16'h0, $urandom);
    txn(2'b01, 16, 16, 16'h0000, $urandom);
    txn(2'b10, 9, 0, 16'h0, $urandom);
    txn(2'b10, 16, 0, 16'h0, $urandom);
    txn(2'b00, 16, 0, 16'h0, {16'h5555, 16'h0033});
    txn(2'b10, 16, 8, 16'($urandom), $urandom);

    for (int t = 0; t < 40; t++) begin
      r   = int'($urandom_range(0, 2));
      csv = (r == 0) ? 2'b10 : (r == 1) ? 2'b01 : 2'b00;
      nrd = ($urandom_range(0, 3) != 0) ? 16 : int'($urandom_range(1, 15));
      r   = int'($urandom_range(0, 3));
      ncmd = (nrd != 16 || r == 0) ? 0 : (r == 1) ? int'($urandom_range(1, 15)) : 16;
      r   = int'($urandom_range(0, 3));
      cmd = (r == 0) ? 16'hFFFF : (r == 1) ? 16'h0000 : 16'($urandom);
      txn(csv, nrd, ncmd, cmd, $urandom);
    end

    // async reset in the middle of a read, with a channel possibly shut down
    txn(2'b01, 16, 16, 16'hFFFF, $urandom);
    bus.temp_in = 32'hFFFF_FFFF;
    bus.cs_n = 2'b10;
    wclk(3);
    for (int i = 0; i < 3; i++) begin
      bus.sck = 1'b1; wclk(4);
      bus.sck = 1'b0; wclk(4);
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_oe", bus.sio_oe, 0);
    chk("arst_out", bus.sio_out, 0);
    chk("arst_sd", bus.shutdown, 0);
    bus.cs_n = '1;
    wclk(4);
    rst = 1'b0;
    m_sd = '0; m_cmd = '0; m_ch = 1'b0;
    wclk(3);
    txn(2'b01, 16, 0, 16'h0, $urandom);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: got running exp finished");
    $fatal(1);
  end
endmodule

// File: doc/spi_temp_sensor_emu.md
Name: spi_temp_sensor_emu

Overview:
- Synthesizable, multi-channel emulator of an LM70-family SPI temperature sensor. It replaces the behavioural sensor model so benches and FPGA builds can run against clock-synchronous RTL.
- Each channel has its own active-low chip select and its own temperature word. All channels share one SCK and one bidirectional SIO pin.
- Supports the read phase (temperature shifted out MSB-first) and the write-back command phase (host to sensor), including shutdown/ID mode.

Parameters:
- NCH, 2, number of emulated sensors (1..8)
- DATA_W, 16, read-frame width in bits
- CMD_W, 16, command-frame width in bits
- ID_CODE, 16'h8001, word returned by a channel in shutdown (DATA_W bits)

Ports:
- clk  input  1  system clock; must be at least 4x SCK frequency
- rst  input  1  asynchronous, active-high reset
- temp_in  input  NCH*DATA_W  per-channel temperature words; channel k is at [k*DATA_W +: DATA_W]
- cs_n  input  NCH  per-channel chip select, active low
- sck  input  1  SPI clock from host (idle low)
- sio_in  input  1  SIO pin as seen by the emulator (host-driven during command phase)
- sio_out  output  1  SIO data driven by the emulator
- sio_oe  output  1  1 = emulator drives SIO
- cmd_valid  output  1  one-cycle pulse when a full command has been received
- cmd_data  output  CMD_W  last received command
- cmd_ch  output  $clog2(NCH) (min 1)  channel of the last command
- frame_done  output  1  one-cycle pulse when a read phase completes
- cs_err  output  1  one-cycle pulse when more than one cs_n is low at frame start
- shutdown  output  NCH  per-channel shutdown state

Behaviour:
- Input synchronisation and edge detection:
  - cs_n, sck and sio_in each pass through a 2-flop synchroniser.
  - Edges are detected from the synchronised signals (previous vs current).
- Reset values: all outputs 0, state IDLE, shift register 0, bit counter 0, shutdown all 0.
- States: IDLE, READ, WRITE, HOLD.
- IDLE:
  - On detection that any synchronised cs_n bit went low, select the lowest-index low channel.
  - If more than one cs_n bit is low, pulse cs_err and still serve the lowest index.
  - Load the shift register with temp_in[ch], or with ID_CODE if shutdown[ch]=1.
  - Set sio_oe=1 and go to READ.
  - Latency: sio_out = MSB valid 3 clk cycles after the cs_n pin falls (2 sync + 1 register).
- READ:
  - Each detected SCK falling edge shifts the register left by 1 and zero-fills; sio_out = shift MSB.
  - SCK rising edges are ignored (the host samples on them).
  - After DATA_W falling edges: pulse frame_done, set sio_oe=0, clear the bit counter, go to WRITE.
- WRITE:
  - Each detected SCK rising edge shifts the synchronised sio_in into the command register, MSB first.
  - After CMD_W rising edges: update cmd_data and cmd_ch, pulse cmd_valid, apply the shutdown rules, go to HOLD.
- HOLD:
  - sio_oe=0; all further SCK edges are ignored.
- CS release:
  - Synchronised cs_n[ch] going high in any non-IDLE state returns the block to IDLE next cycle with sio_oe=0.
  - A partial command is discarded: no cmd_valid, no cmd_data update.
  - A partial read gives no frame_done.
- CS changes mid-frame:
  - Changes on cs_n bits other than the selected channel are ignored until IDLE.
- temp_in sampling:
  - temp_in is sampled only at frame start; later changes do not affect the frame in progress.
- Bit counter:
  - Width $clog2(max(DATA_W,CMD_W)+1).
  - Does not wrap within a phase.
  - Excess SCK edges in HOLD have no effect.
- Reset asserted mid-frame: immediate return to reset values, including shutdown.

Optional Feature:
- Macro: SENSOR_SHUTDOWN_EN.
- Defined:
  - A received command of all ones sets shutdown[cmd_ch].
  - All zeros clears shutdown[cmd_ch].
  - Other values leave shutdown unchanged.
  - A shut-down channel returns ID_CODE on subsequent reads.
- Not defined:
  - shutdown is tied to 0.
  - Reads always return temp_in.
  - cmd_valid and cmd_data still operate.

Test Plan:
- Reset then single read, NCH=2, temp_in ch0=16'h0033, cs_n=2'b10, 16 SCK cycles:
  - sio_out serial sequence is 0x0033 MSB-first;
  - frame_done pulses once;
  - sio_oe falls after the 16th falling edge.
- Command write on ch1, with SENSOR_SHUTDOWN_EN:
  - Send 16 read bits, then host drives 16'hFFFF → cmd_valid pulse, cmd_data=16'hFFFF, cmd_ch=1, shutdown=2'b10.
  - Next ch1 read returns 16'h8001.
  - Then command 16'h0000 → shutdown=2'b00.
- Abort: cs_n rises after 9 SCK falling edges → no frame_done, state IDLE, sio_oe=0. Next frame returns the full word correctly.
- Simultaneous CS: cs_n=2'b00 at start → cs_err pulses once; ch0 data (0x0033) is returned.
- Partial command: cs_n rises after 8 command bits → no cmd_valid; cmd_data keeps its previous value.
- Async reset asserted mid-READ → sio_oe=0, sio_out=0 and shutdown=0 immediately, without waiting for a clk edge.
